// File: rtl/core_rf_sb.sv
// Multi-ported register file with a per-register busy scoreboard.
// Highest-indexed write port wins collisions; reads optionally forward same-cycle writes.
module core_rf_sb #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned R_PORTS  = 4,
    parameter int unsigned W_PORTS  = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_R0  = 1,
    localparam int unsigned AW      = $clog2(NUM_REGS)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [R_PORTS*AW-1:0]       rd_addr_i,
    output logic [R_PORTS*DATA_W-1:0]   rd_data_o,
    output logic [R_PORTS-1:0]          rd_busy_o,
    input  logic [W_PORTS-1:0]          wr_en_i,
    input  logic [W_PORTS*AW-1:0]       wr_addr_i,
    input  logic [W_PORTS*DATA_W-1:0]   wr_data_i,
    input  logic [W_PORTS-1:0]          claim_en_i,
    input  logic [W_PORTS*AW-1:0]       claim_addr_i,
    input  logic                        flush_i,
    output logic [AW:0]                 busy_cnt_o
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [AW:0]         cnt_d;
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] claim_hit;
    logic [DATA_W-1:0]   wr_val [NUM_REGS];

    // Per-register write winner (later ports overwrite earlier) and claim decode
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_hit[r]    = 1'b0;
            claim_hit[r] = 1'b0;
            wr_val[r]    = '0;
            for (int p = 0; p < W_PORTS; p++) begin
                if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] == AW'(r))) begin
                    wr_hit[r] = 1'b1;
                    wr_val[r] = wr_data_i[p*DATA_W +: DATA_W];
                end
                if (claim_en_i[p] && (claim_addr_i[p*AW +: AW] == AW'(r))) begin
                    claim_hit[r] = 1'b1;
                end
            end
        end
        if (ZERO_R0 != 0) begin
            wr_hit[0]    = 1'b0;
            claim_hit[0] = 1'b0;
        end
    end

    // Writes retire busy, claims re-arm it, flush wins over both
    always_comb begin
        busy_d = (busy_q & ~wr_hit) | claim_hit;
        if (flush_i) begin
            busy_d = '0;
        end
        cnt_d = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d = cnt_d + (AW+1)'(busy_d[r]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_o <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (wr_hit[r]) begin
                    regs_q[r] <= wr_val[r];
                end
            end
            busy_q     <= busy_d;
            busy_cnt_o <= cnt_d;
        end
    end

    // Read ports with optional forwarding of the winning same-cycle write
    always_comb begin
        for (int p = 0; p < R_PORTS; p++) begin
            rd_data_o[p*DATA_W +: DATA_W] = regs_q[rd_addr_i[p*AW +: AW]];
            rd_busy_o[p]                  = busy_q[rd_addr_i[p*AW +: AW]];
            if ((BYPASS != 0) && wr_hit[rd_addr_i[p*AW +: AW]]) begin
                rd_data_o[p*DATA_W +: DATA_W] = wr_val[rd_addr_i[p*AW +: AW]];
                rd_busy_o[p]                  = 1'b0;
            end
            if ((ZERO_R0 != 0) && (rd_addr_i[p*AW +: AW] == '0)) begin
                rd_data_o[p*DATA_W +: DATA_W] = '0;
                rd_busy_o[p]                  = 1'b0;
            end
        end
    end

endmodule

// File: doc/core_rf_sb.md
CORE_RF_SB -- requirements
Module: core_rf_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 16: register count, power of two, >=2; AW = log2(NUM_REGS).
REQ-003 SHALL have parameter R_PORTS, default 4: number of read ports.
REQ-004 SHALL have parameter W_PORTS, default 2: number of write ports, also the number of claim ports.
REQ-005 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding; 0 = reads return stored value only.
REQ-006 SHALL have parameter ZERO_R0, default 1: 1 = register 0 reads 0, ignores writes, is never busy.
REQ-007 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-008 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port rd_addr_i, input, R_PORTS*AW: read address per port, port p at bits [p*AW +: AW].
REQ-010 SHALL have port rd_data_o, output, R_PORTS*DATA_W: read data per port.
REQ-011 SHALL have port rd_busy_o, output, R_PORTS: scoreboard busy flag for the addressed register, per read port.
REQ-012 SHALL have port wr_en_i, input, W_PORTS: write enable per write port.
REQ-013 SHALL have port wr_addr_i, input, W_PORTS*AW: write address per write port.
REQ-014 SHALL have port wr_data_i, input, W_PORTS*DATA_W: write data per write port.
REQ-015 SHALL have port claim_en_i, input, W_PORTS: claim request per port; marks the destination register pending.
REQ-016 SHALL have port claim_addr_i, input, W_PORTS*AW: claimed register per port.
REQ-017 SHALL have port flush_i, input, 1: clears all busy bits.
REQ-018 SHALL have port busy_cnt_o, output, AW+1: number of busy registers.

Function
REQ-019 SHALL store NUM_REGS x DATA_W registers; write on wr_en_i takes effect at the next rising edge.
REQ-020 SHALL, when several write ports with wr_en_i set target one register in a cycle, store the data of the highest-indexed such port; no OR-merging of data.
REQ-021 SHALL drive rd_data_o combinationally from rd_addr_i: stored value when BYPASS=0; when BYPASS=1 and a same-cycle enabled write targets the address, the winning write data per REQ-020.
REQ-022 SHALL hold one busy bit per register; claim_en_i sets it at the next edge, wr_en_i to that register clears it at the next edge.
REQ-023 SHALL give claim priority over write when both target one register in the same cycle: busy ends set, data still written.
REQ-024 SHALL, on flush_i, clear every busy bit at the next edge, overriding same-cycle claims; same-cycle writes still update data.
REQ-025 SHALL drive rd_busy_o combinationally: stored busy bit; when BYPASS=1, forced 0 if a same-cycle enabled write targets the address.
REQ-026 SHALL, with ZERO_R0=1, return 0 on rd_data_o and 0 on rd_busy_o for address 0, including under bypass, and drop writes and claims to register 0.
REQ-027 SHALL drive busy_cnt_o registered, equal to the population count of busy bits after the edge; range 0..NUM_REGS.
REQ-028 SHALL treat a write to a non-busy register as a plain write; busy unaffected.
REQ-029 SHALL treat duplicate claims to one register in a cycle as a single claim.

Reset
REQ-030 SHALL, with rst_i high at a rising edge, set all registers to 0, all busy bits to 0, busy_cnt_o to 0; rst_i overrides same-cycle writes, claims and flush.
REQ-031 SHALL, after reset, present rd_data_o = 0 and rd_busy_o = 0 for every address, except when a bypassed write is present in that cycle.

Verification
REQ-032 SHALL pass: write port 0 R3=0x1234, next cycle read R3 on all ports -> 0x1234; same cycle with BYPASS=1 -> 0x1234, with BYPASS=0 -> old value 0.
REQ-033 SHALL pass: port0 writes R5=0xAAAA and port1 writes R5=0x5555 in the same cycle -> R5 reads 0x5555.
REQ-034 SHALL pass: claim R7 -> rd_busy_o=1 and busy_cnt_o=1 next cycle; write R7=0x0042 -> same cycle rd_busy_o=0 (BYPASS=1), next cycle busy_cnt_o=0 and data 0x0042.
REQ-035 SHALL pass: claim and write R9 in the same cycle -> R9 busy afterwards with new data; then flush_i alongside a claim of R2 -> busy_cnt_o=0.
REQ-036 SHALL pass: write R0=0xFFFF and claim R0 with ZERO_R0=1 -> R0 reads 0, rd_busy_o=0, busy_cnt_o unchanged.
REQ-037 SHALL pass: claim all 15 non-zero registers, then assert rst_i together with writes -> busy_cnt_o=0 and all reads 0.
